uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Serial-to-parallel UART receive stage, downstream counterpart of Transmitter.
//   Consumes the 8N1 TxD line (idle high, start 0, 8 data LSB-first, stop 1).
//   Synchronises the line, validates the start bit, samples mid-bit and emits
//   one byte per frame with a single-cycle valid strobe.
//   Sits at the chip pad boundary; feeds byte-wide logic on clk.
// PARAMETERS
//   CLK_FREQ   100_000_000  system clock frequency in Hz
//   BAUD       9600         line rate in bit/s
//   (localparam CLKS_PER_BIT = CLK_FREQ/BAUD = 10416; HALF_BIT = CLKS_PER_BIT/2 = 5208)
// PORTS
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   RxD        in   1  serial line, asynchronous to clk, idle high
//   rx_data    out  8  last correctly framed byte, held until next good frame
//   rx_valid   out  1  1-cycle pulse: rx_data updated this cycle
//   rx_busy    out  1  high while not in IDLE
//   frame_err  out  1  1-cycle pulse: stop bit sampled 0
//   parity_err out  1  1-cycle pulse: parity mismatch (tied 0 unless UART_RX_PARITY_EN)
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE, counters 0, sync FFs 1,
//     rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, parity_err=0.
//   - RxD passes a 2-FF synchroniser (reset value 1); FSM sees rxd_s only.
//   - 14-bit baud counter cnt, 3-bit bit index idx, 8-bit shift register sr.
//   - IDLE: rxd_s==0 -> START, cnt=0.
//   - START: on cnt==HALF_BIT-1 sample rxd_s; 0 -> DATA, cnt=0, idx=0;
//     1 -> IDLE (glitch rejected, no strobe). Otherwise cnt++.
//   - DATA: on cnt==CLKS_PER_BIT-1 sample: sr <= {rxd_s, sr[7:1]}, cnt=0;
//     idx==7 -> STOP (or PARITY when enabled), else idx++.
//   - STOP: on cnt==CLKS_PER_BIT-1 sample rxd_s; 1 -> rx_data<=sr, rx_valid=1;
//     0 -> frame_err=1, rx_data unchanged. Always -> IDLE the same cycle, so a
//     start bit immediately after mid-stop is detected (back-to-back frames).
//   - Strobes rx_valid/frame_err/parity_err are registered, high exactly 1 cycle,
//     never simultaneously high.
//   - Latency: rx_valid rises 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT clocks (+1 reg)
//     after the RxD falling edge of the start bit.
//   - RxD changes mid-bit are ignored; only the mid-bit sample counts (no voting).
//   - Reset mid-frame aborts the frame: no strobe, partial sr discarded.
//   - cnt never wraps: reset to 0 at each terminal compare.
// CONFIGURATION
//   UART_RX_PARITY_EN defined: frame is 8E1; extra PARITY state after DATA,
//     one bit time; sampled bit must equal ^sr (even parity). Mismatch ->
//     parity_err pulse at stop sample, rx_valid suppressed, rx_data unchanged;
//     frame_err takes priority if both fail.
//   Undefined: 8N1, no PARITY state, parity_err tied 0.
// TESTING
//   Default params, 100 MHz clk; per-bit period 104160 ns.
//   T1 reset: rst_n=0 at any time -> rx_data=00, all strobes 0, rx_busy=0.
//   T2 frame 0xAB with good stop -> single rx_valid, rx_data=AB, frame_err=0.
//   T3 back-to-back 0xAA,0xBB,0xCC, one stop bit each, no idle gap -> three
//     rx_valid pulses in order, data AA,BB,CC, no errors.
//   T4 RxD low for 3000 clocks then high -> rx_busy returns 0 after HALF_BIT,
//     no strobe; following 0x55 frame received correctly.
//   T5 0x55 with stop bit 0 -> frame_err pulse, no rx_valid, rx_data keeps
//     previous value.
//   T6 rst_n pulsed low during data bit 4 of 0xF0 -> no strobe; next frame 0x3C
//     -> rx_data=3C. With UART_RX_PARITY_EN: 0xAB with parity 1 -> rx_valid;
//     parity 0 -> parity_err, no rx_valid.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receive stage.
// Double-flops the asynchronous RxD line, checks the start bit at half a bit
// time, then samples each data bit and the stop bit in mid-bit. Each frame ends
// in at most one single-cycle strobe: rx_valid, frame_err or parity_err.
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames, which adds one
// even-parity bit after the data bits.
module uart_receiver #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [13:0] CNT_BIT_END  = 14'(CLKS_PER_BIT - 1);
  localparam logic [13:0] CNT_HALF_END = 14'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_e      state_q;
  logic [13:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  sr_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        frame_err_q;
  logic        rxd_meta_q;
  logic        rxd_s_q;
`ifdef UART_RX_PARITY_EN
  logic        par_ok_q;
  logic        parity_err_q;
`endif

  // Two-flop synchroniser; it resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= RxD;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Frame FSM with bit timing, shifting and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 14'd0;
      idx_q        <= 3'd0;
      sr_q         <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q     <= 1'b1;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          cnt_q <= 14'd0;
          if (!rxd_s_q) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF_END) begin
            cnt_q <= 14'd0;
            idx_q <= 3'd0;
            // A line that is high again by mid-start is a glitch. Drop it silently.
            state_q <= rxd_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 14'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_BIT_END) begin
            cnt_q <= 14'd0;
            sr_q  <= {rxd_s_q, sr_q[7:1]};
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 14'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_BIT_END) begin
            cnt_q    <= 14'd0;
            par_ok_q <= (rxd_s_q == even_parity(sr_q));
            state_q  <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 14'd1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == CNT_BIT_END) begin
            cnt_q <= 14'd0;
            // Return to IDLE at mid-stop so a back-to-back start bit is seen in time.
            state_q <= S_IDLE;
            if (!rxd_s_q) begin
              frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (!par_ok_q) begin
              parity_err_q <= 1'b1;
`endif
            end else begin
              rx_data_q  <= sr_q;
              rx_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 14'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 14'd0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver. A scaled baud rate gives 16 clocks per bit.
// Stimulus tasks push the expected outcome of each frame into a queue.
// A negedge monitor pops one entry per strobe and compares it.
module tb_uart_receiver;

  localparam int CF   = 1_600_000;
  localparam int BD   = 100_000;
  localparam int C    = CF / BD;
  localparam int HALF = C / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RxD;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  typedef struct {
    int         kind;   // 0 = good byte, 1 = framing error, 2 = parity error
    logic [7:0] data;   // rx_data value expected while the strobe is high
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         vectors    = 0;
  int         miscompares = 0;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  uart_receiver #(.CLK_FREQ(CF), .BAUD(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RxD        (RxD),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Hold the line at v for n bit-clocks. Entry and exit are at posedge + 1 ns.
  task automatic hold(input logic v, input int n);
    RxD = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one frame. If rst_bit >= 0, rst_n is pulsed in the middle of that data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                            input logic par_bit, input int rst_bit);
    exp_t e;
    if (rst_bit < 0) begin
      if (!stop_ok) begin
        e.kind = 1; e.data = last_good;
      end else if (PAR_EN && (par_bit != ^d)) begin
        e.kind = 2; e.data = last_good;
      end else begin
        e.kind = 0; e.data = d; last_good = d;
      end
      exp_q.push_back(e);
    end
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        hold(d[i], HALF);
        rst_n = 1'b0;
        last_good = 8'h00;
        hold(d[i], 2);
        rst_n = 1'b1;
        hold(d[i], C - HALF - 2);
      end else begin
        hold(d[i], C);
      end
    end
    if (PAR_EN) hold(par_bit, C);
    if (stop_ok) begin
      hold(1'b1, C);
    end else begin
      // Release the line early so the tail of the bad stop bit cannot look like a start bit.
      hold(1'b0, C - 4);
      hold(1'b1, 4);
    end
  endtask

  // Scoreboard monitor: each strobe must match the oldest pending expectation.
  always @(negedge clk) begin : monitor
    int   kind;
    exp_t e;
    if (rst_n && (rx_valid || frame_err || parity_err)) begin
      check("strobe_exclusive", 32'(rx_valid) + 32'(frame_err) + 32'(parity_err), 32'd1);
      kind = rx_valid ? 0 : (frame_err ? 1 : 2);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got kind %0d data %0h expected no strobe", kind, rx_data);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 32'(kind), 32'(e.kind));
        check("strobe_data", {24'd0, rx_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       sok;
    logic       pb;
    RxD = 1'b1;
    rst_n = 1'b0;
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_strobes", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
    check("reset_busy", {31'd0, rx_busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold(1'b1, 2 * C);

    // Single good frame.
    send_frame(8'hAB, 1'b1, ^8'hAB, -1);
    hold(1'b1, C);
    check("t2_rx_data", {24'd0, rx_data}, 32'hAB);

    // Three back-to-back frames with no idle gap.
    send_frame(8'hAA, 1'b1, ^8'hAA, -1);
    send_frame(8'hBB, 1'b1, ^8'hBB, -1);
    send_frame(8'hCC, 1'b1, ^8'hCC, -1);
    hold(1'b1, 2 * C);

    // A short low glitch is rejected and leaves no strobe.
    hold(1'b0, 4);
    @(negedge clk);
    check("t4_busy_during_glitch", {31'd0, rx_busy}, 32'd1);
    @(posedge clk); #1;
    hold(1'b1, HALF + 4);
    @(negedge clk);
    check("t4_busy_after_glitch", {31'd0, rx_busy}, 32'd0);
    @(posedge clk); #1;
    send_frame(8'h55, 1'b1, ^8'h55, -1);
    hold(1'b1, C);

    // Bad stop bit: framing error, rx_data keeps 0x55.
    send_frame(8'h55, 1'b0, ^8'h55, -1);
    hold(1'b1, 2 * C);
    check("t5_rx_data_held", {24'd0, rx_data}, 32'h55);

    // Reset during data bit 4 aborts the frame. The next frame is clean.
    send_frame(8'hF0, 1'b1, ^8'hF0, 4);
    hold(1'b1, C);
    check("t6_rx_data_after_reset", {24'd0, rx_data}, 32'h00);
    check("t6_busy_after_reset", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h3C, 1'b1, ^8'h3C, -1);
    hold(1'b1, C);
    check("t6_rx_data", {24'd0, rx_data}, 32'h3C);

`ifdef UART_RX_PARITY_EN
    send_frame(8'hAB, 1'b1, 1'b1, -1);
    send_frame(8'hAB, 1'b1, 1'b0, -1);
    hold(1'b1, 2 * C);
`endif

    // Random frames with occasional bad stop or parity bits and random idle gaps.
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      sok = ($urandom_range(0, 4) != 0);
      pb  = (^d) ^ (PAR_EN && ($urandom_range(0, 4) == 0));
      send_frame(d, sok, pb, -1);
      if (sok) hold(1'b1, int'($urandom_range(0, 1)) * C);
      else     hold(1'b1, 2 * C);
    end

    hold(1'b1, 3 * C);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    check("final_rx_data", {24'd0, rx_data}, {24'd0, last_good});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
